// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory port of mem_arbiter.
// The arbiter uses the slave view; the environment (requesters + memory)
// uses the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester (read only)
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_resp_valid;
  logic              if_resp_ready;
  logic [DATA_W-1:0] if_rdata;

  // Load/store requester (read or masked write)
  logic              ls_req_valid;
  logic              ls_req_ready;
  logic              ls_wen;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [7:0]        ls_mask;
  logic              ls_resp_valid;
  logic              ls_resp_ready;
  logic [DATA_W-1:0] ls_rdata;

  // Single-port memory, combinational read data
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_mask;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr, if_resp_ready,
    input  ls_req_valid, ls_wen, ls_addr, ls_wdata, ls_mask, ls_resp_ready,
    input  mem_rdata,
    output if_req_ready, if_resp_valid, if_rdata,
    output ls_req_ready, ls_resp_valid, ls_rdata,
    output mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_mask
  );

  modport master (
    output if_req_valid, if_addr, if_resp_ready,
    output ls_req_valid, ls_wen, ls_addr, ls_wdata, ls_mask, ls_resp_ready,
    output mem_rdata,
    input  if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_ready, ls_resp_valid, ls_rdata,
    input  mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_mask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter. One transaction at a time moves through
// IDLE (grant/accept) -> ACCESS (single memory cycle) -> RESP (hold the
// response until the owner takes it). Ties are broken round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;

  state_e            state_q, state_d;
  owner_e            last_grant_q, last_grant_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        mask_q, mask_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;

  logic grant_if;
  logic grant_ls;
  logic accept;
  logic in_access;
  logic in_resp;
  logic owner_ready;

  // Grant decision: only meaningful in IDLE; ties go to whoever lost last time
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state_q == IDLE) begin
      if (bus.if_req_valid && bus.ls_req_valid) begin
        if (last_grant_q == OWN_LS) grant_if = 1'b1;
        else                        grant_ls = 1'b1;
      end else begin
        grant_if = bus.if_req_valid;
        grant_ls = bus.ls_req_valid;
      end
    end
  end

  assign accept      = grant_if | grant_ls;
  assign in_access   = (state_q == ACCESS);
  assign in_resp     = (state_q == RESP);
  assign owner_ready = (owner_q == OWN_LS) ? bus.ls_resp_ready : bus.if_resp_ready;

  // Next state plus transaction latches; the latches only move on acceptance
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    rbuf_d       = rbuf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = ACCESS;
          last_grant_d = grant_ls ? OWN_LS : OWN_IF;
          owner_d      = grant_ls ? OWN_LS : OWN_IF;
          addr_d       = grant_ls ? bus.ls_addr : bus.if_addr;
          wen_d        = grant_ls & bus.ls_wen;
          wdata_d      = grant_ls ? bus.ls_wdata : '0;
          mask_d       = grant_ls ? bus.ls_mask : 8'h00;
        end
      end
      ACCESS: begin
        state_d = RESP;
        rbuf_d  = wen_q ? '0 : bus.mem_rdata;
      end
      RESP: begin
        if (owner_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_LS;
      owner_q      <= OWN_IF;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      mask_q       <= 8'h00;
      rbuf_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      rbuf_q       <= rbuf_d;
    end
  end

  // Requester handshakes: readies only from IDLE, responses only to the owner
  assign bus.if_req_ready  = grant_if;
  assign bus.ls_req_ready  = grant_ls;
  assign bus.if_resp_valid = in_resp && (owner_q == OWN_IF);
  assign bus.ls_resp_valid = in_resp && (owner_q == OWN_LS);
  assign bus.if_rdata      = bus.if_resp_valid ? rbuf_q : '0;
  assign bus.ls_rdata      = bus.ls_resp_valid ? rbuf_q : '0;

  // Memory port: one strobe during ACCESS, everything zero otherwise
  assign bus.mem_ren   = in_access && !wen_q;
  assign bus.mem_wen   = in_access && wen_q;
  assign bus.mem_raddr = bus.mem_ren ? addr_q : '0;
  assign bus.mem_waddr = bus.mem_wen ? addr_q : '0;
  assign bus.mem_wdata = bus.mem_wen ? wdata_q : '0;
  assign bus.mem_mask  = bus.mem_wen ? mask_q : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed transactions with literal expectations,
// plus a transaction-level model checked against every output each cycle.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        if_v;
    logic [31:0] if_addr;
    logic        if_rr;
    logic        ls_v;
    logic        ls_wen;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [7:0]  ls_mask;
    logic        ls_rr;
    logic [31:0] mem_rdata;
  } stim_t;

  stim_t cur;
  int    checks;
  int    failures;
  int    grant_log[$];

  // Transaction model: idle, or holding one transaction at phase 1 (memory
  // cycle) or phase 2 (waiting for the owner to take the response)
  logic        m_busy;
  int          m_phase;
  logic        m_owner_ls;
  logic        m_last_ls;
  logic [31:0] m_addr;
  logic        m_wen;
  logic [31:0] m_wdata;
  logic [7:0]  m_mask;
  logic [31:0] m_rbuf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    bus.if_req_valid  = s.if_v;
    bus.if_addr       = s.if_addr;
    bus.if_resp_ready = s.if_rr;
    bus.ls_req_valid  = s.ls_v;
    bus.ls_wen        = s.ls_wen;
    bus.ls_addr       = s.ls_addr;
    bus.ls_wdata      = s.ls_wdata;
    bus.ls_mask       = s.ls_mask;
    bus.ls_resp_ready = s.ls_rr;
    bus.mem_rdata     = s.mem_rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Per-cycle comparison against the model, then advance the model to the next edge
  always @(negedge clk) begin
    logic        busy_now, last_now, pick_ls;
    logic        e_if_rdy, e_ls_rdy, e_ren, e_wen, e_if_rv, e_ls_rv;
    logic [31:0] e_raddr, e_waddr, e_wdata, e_if_rd, e_ls_rd;
    logic [7:0]  e_mask;
    busy_now = rst_n && m_busy;
    last_now = rst_n && m_last_ls;
    pick_ls  = (bus.if_req_valid && bus.ls_req_valid) ? !last_now : bus.ls_req_valid;
    e_if_rdy = 1'b0; e_ls_rdy = 1'b0; e_ren = 1'b0; e_wen = 1'b0;
    e_if_rv = 1'b0; e_ls_rv = 1'b0; e_raddr = '0; e_waddr = '0;
    e_wdata = '0; e_mask = '0; e_if_rd = '0; e_ls_rd = '0;
    if (!busy_now) begin
      e_if_rdy = bus.if_req_valid && !pick_ls;
      e_ls_rdy = bus.ls_req_valid && pick_ls;
    end else if (m_phase == 1) begin
      if (m_wen) begin
        e_wen = 1'b1; e_waddr = m_addr; e_wdata = m_wdata; e_mask = m_mask;
      end else begin
        e_ren = 1'b1; e_raddr = m_addr;
      end
    end else if (m_owner_ls) begin
      e_ls_rv = 1'b1; e_ls_rd = m_rbuf;
    end else begin
      e_if_rv = 1'b1; e_if_rd = m_rbuf;
    end
    checkOutput("m_if_req_ready", bus.if_req_ready, e_if_rdy);
    checkOutput("m_ls_req_ready", bus.ls_req_ready, e_ls_rdy);
    checkOutput("m_mem_ren", bus.mem_ren, e_ren);
    checkOutput("m_mem_wen", bus.mem_wen, e_wen);
    checkOutput("m_mem_raddr", bus.mem_raddr, e_raddr);
    checkOutput("m_mem_waddr", bus.mem_waddr, e_waddr);
    checkOutput("m_mem_wdata", bus.mem_wdata, e_wdata);
    checkOutput("m_mem_mask", bus.mem_mask, e_mask);
    checkOutput("m_if_resp_valid", bus.if_resp_valid, e_if_rv);
    checkOutput("m_ls_resp_valid", bus.ls_resp_valid, e_ls_rv);
    checkOutput("m_if_rdata", bus.if_rdata, e_if_rd);
    checkOutput("m_ls_rdata", bus.ls_rdata, e_ls_rd);
    checkOutput("m_mem_exclusive", bus.mem_ren & bus.mem_wen, 1'b0);
    if (bus.if_req_valid && bus.if_req_ready) grant_log.push_back(0);
    if (bus.ls_req_valid && bus.ls_req_ready) grant_log.push_back(1);
    if (!rst_n) begin
      m_busy <= 1'b0; m_phase <= 0; m_last_ls <= 1'b1;
    end else if (!busy_now) begin
      if (bus.if_req_valid || bus.ls_req_valid) begin
        m_busy     <= 1'b1;
        m_phase    <= 1;
        m_owner_ls <= pick_ls;
        m_last_ls  <= pick_ls;
        m_addr     <= pick_ls ? bus.ls_addr : bus.if_addr;
        m_wen      <= pick_ls && bus.ls_wen;
        m_wdata    <= bus.ls_wdata;
        m_mask     <= bus.ls_mask;
      end
    end else if (m_phase == 1) begin
      m_rbuf  <= m_wen ? 32'h0 : bus.mem_rdata;
      m_phase <= 2;
    end else if (m_owner_ls ? bus.ls_resp_ready : bus.if_resp_ready) begin
      m_busy <= 1'b0;
    end
  end

  // Hard stop in case the directed sequence never completes
  initial begin
    #200000;
    $display("[TB] FAIL timeout: actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence with hand-computed literal expectations
  initial begin
    int exp_order[4];
    logic [63:0] got;
    exp_order = '{0, 1, 0, 1};
    checks = 0; failures = 0;
    m_busy = 1'b0; m_phase = 0; m_last_ls = 1'b1; m_owner_ls = 1'b0;
    m_addr = '0; m_wen = 1'b0; m_wdata = '0; m_mask = '0; m_rbuf = '0;
    rst_n = 1'b0;
    cur = '0;
    applyStimulus(cur);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_ren", bus.mem_ren, 0);
    checkOutput("rst_mem_wen", bus.mem_wen, 0);
    checkOutput("rst_if_resp_valid", bus.if_resp_valid, 0);
    checkOutput("rst_ls_resp_valid", bus.ls_resp_valid, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] IF read alone");
    cur.if_v = 1; cur.if_addr = 32'h8000_0000; cur.if_rr = 1; cur.mem_rdata = 32'h0000_0413;
    applyStimulus(cur);
    checkOutput("if_rd_req_ready", bus.if_req_ready, 1);
    checkOutput("if_rd_ls_req_ready", bus.ls_req_ready, 0);
    tick();
    cur.if_v = 0; cur.if_addr = 32'h1234_5678;
    applyStimulus(cur);
    checkOutput("if_rd_mem_ren", bus.mem_ren, 1);
    checkOutput("if_rd_mem_raddr", bus.mem_raddr, 32'h8000_0000);
    checkOutput("if_rd_resp_early", bus.if_resp_valid, 0);
    tick();
    cur.mem_rdata = 32'hFFFF_FFFF;
    applyStimulus(cur);
    checkOutput("if_rd_resp_valid", bus.if_resp_valid, 1);
    checkOutput("if_rd_rdata", bus.if_rdata, 32'h0000_0413);
    checkOutput("if_rd_mem_ren_off", bus.mem_ren, 0);
    tick();
    applyStimulus(cur);
    checkOutput("if_rd_resp_done", bus.if_resp_valid, 0);
    checkOutput("if_rd_rdata_zero", bus.if_rdata, 0);

    $display("[TB] LS write");
    cur.ls_v = 1; cur.ls_wen = 1; cur.ls_addr = 32'h8000_1000;
    cur.ls_wdata = 32'hDEAD_BEEF; cur.ls_mask = 8'h0F; cur.ls_rr = 1;
    applyStimulus(cur);
    checkOutput("ls_wr_req_ready", bus.ls_req_ready, 1);
    tick();
    cur.ls_v = 0; cur.ls_wdata = 32'h0; cur.ls_mask = 8'hFF;
    applyStimulus(cur);
    checkOutput("ls_wr_mem_wen", bus.mem_wen, 1);
    checkOutput("ls_wr_mem_ren", bus.mem_ren, 0);
    checkOutput("ls_wr_waddr", bus.mem_waddr, 32'h8000_1000);
    checkOutput("ls_wr_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    checkOutput("ls_wr_mask", bus.mem_mask, 8'h0F);
    tick();
    applyStimulus(cur);
    checkOutput("ls_wr_resp_valid", bus.ls_resp_valid, 1);
    checkOutput("ls_wr_rdata", bus.ls_rdata, 0);
    checkOutput("ls_wr_mem_wen_off", bus.mem_wen, 0);
    tick();
    applyStimulus(cur);
    checkOutput("ls_wr_resp_done", bus.ls_resp_valid, 0);

    $display("[TB] LS write with empty mask");
    cur.ls_v = 1; cur.ls_wen = 1; cur.ls_addr = 32'h40; cur.ls_wdata = 32'h55; cur.ls_mask = 8'h00;
    applyStimulus(cur);
    tick();
    cur.ls_v = 0;
    applyStimulus(cur);
    checkOutput("mask0_mem_wen", bus.mem_wen, 1);
    checkOutput("mask0_mem_mask", bus.mem_mask, 0);
    tick();
    tick();
    applyStimulus(cur);

    $display("[TB] round-robin from reset");
    cur = '0;
    applyStimulus(cur);
    resetPulse();
    grant_log.delete();
    cur.if_v = 1; cur.if_addr = 32'h1000; cur.if_rr = 1;
    cur.ls_v = 1; cur.ls_wen = 1; cur.ls_addr = 32'h2000; cur.ls_wdata = 32'hA5A5_A5A5;
    cur.ls_mask = 8'h3C; cur.ls_rr = 1; cur.mem_rdata = 32'h77;
    applyStimulus(cur);
    repeat (12) tick();
    cur.if_v = 0; cur.ls_v = 0;
    applyStimulus(cur);
    checkOutput("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < grant_log.size()) ? 64'(grant_log[i]) : 64'hFF;
      checkOutput($sformatf("rr_order%0d", i), got, 64'(exp_order[i]));
    end

    $display("[TB] LS response backpressure");
    cur.ls_v = 1; cur.ls_wen = 0; cur.ls_addr = 32'h100; cur.ls_rr = 0; cur.mem_rdata = 32'hCAFE_0001;
    applyStimulus(cur);
    checkOutput("bp_ls_req_ready", bus.ls_req_ready, 1);
    tick();
    cur.ls_v = 0; cur.if_v = 1; cur.if_addr = 32'h200; cur.if_rr = 1;
    applyStimulus(cur);
    checkOutput("bp_mem_raddr", bus.mem_raddr, 32'h100);
    checkOutput("bp_if_req_ready_acc", bus.if_req_ready, 0);
    tick();
    cur.mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      cur.ls_v = (i == 2);
      applyStimulus(cur);
      checkOutput($sformatf("bp_ls_resp_valid%0d", i), bus.ls_resp_valid, 1);
      checkOutput($sformatf("bp_ls_rdata%0d", i), bus.ls_rdata, 32'hCAFE_0001);
      checkOutput($sformatf("bp_if_req_ready%0d", i), bus.if_req_ready, 0);
      tick();
    end
    cur.ls_v = 0; cur.ls_rr = 1;
    applyStimulus(cur);
    checkOutput("bp_release_valid", bus.ls_resp_valid, 1);
    tick();
    applyStimulus(cur);
    checkOutput("bp_ls_resp_done", bus.ls_resp_valid, 0);
    checkOutput("bp_if_granted", bus.if_req_ready, 1);
    tick();
    cur.if_v = 0;
    applyStimulus(cur);
    checkOutput("bp_if_mem_raddr", bus.mem_raddr, 32'h200);
    tick();
    applyStimulus(cur);
    checkOutput("bp_if_rdata", bus.if_rdata, 32'h1111_2222);
    tick();

    $display("[TB] reset during access");
    cur = '0;
    cur.if_v = 1; cur.if_addr = 32'h300; cur.if_rr = 1; cur.mem_rdata = 32'h99;
    applyStimulus(cur);
    tick();
    cur.if_v = 0;
    applyStimulus(cur);
    checkOutput("ar_mem_ren_before", bus.mem_ren, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("ar_mem_ren_async", bus.mem_ren, 0);
    checkOutput("ar_mem_raddr_async", bus.mem_raddr, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(cur);
      checkOutput($sformatf("ar_no_resp%0d", i), bus.if_resp_valid, 0);
      tick();
    end
    cur.if_v = 1; cur.ls_v = 1; cur.ls_wen = 0; cur.ls_addr = 32'h400; cur.ls_rr = 1;
    applyStimulus(cur);
    checkOutput("ar_tie_if_ready", bus.if_req_ready, 1);
    checkOutput("ar_tie_ls_ready", bus.ls_req_ready, 0);
    tick();
    cur.if_v = 0; cur.ls_v = 0;
    applyStimulus(cur);
    tick();
    applyStimulus(cur);
    checkOutput("ar_tie_if_rdata", bus.if_rdata, 32'h99);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
